// File: rtl/wb_resp_pipe.sv
// wb_resp_pipe: single-outstanding Wishbone bridge with watchdog and a STAGES-deep response pipeline.
module wb_resp_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int STAGES  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_core,
  input  logic                rst_core,
  input  logic                m_cyc,
  input  logic                m_stb,
  input  logic                m_we,
  input  logic [DATA_W/8-1:0] m_sel,
  input  logic [ADDR_W-1:0]   m_addr,
  input  logic [DATA_W-1:0]   m_data_o,
  output logic [DATA_W-1:0]   m_data_i,
  output logic                m_ack,
  output logic                m_err,
  output logic                m_stall,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [DATA_W/8-1:0] s_sel,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_data_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_ack
);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic r_we;
  logic [DATA_W/8-1:0] r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [STAGES-1:0] v, e;
  logic [DATA_W-1:0] d [STAGES];
  logic acc, cap, hit;
  // s_ack outranks an expiring watchdog; an abort (m_cyc low) outranks both
  always_comb begin
    hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));
    acc = (state == IDLE) && m_cyc && m_stb;
    cap = (state == REQ) && m_cyc && (s_ack || hit);
    state_nx = (state == IDLE) ? (acc ? REQ : IDLE) :
               (state == REQ)  ? (!m_cyc ? IDLE : cap ? RESP : REQ) :
               (state == RESP) ? (v[STAGES-1] ? IDLE : RESP) : IDLE;
  end
  assign s_cyc    = (state == REQ);
  assign s_stb    = (state == REQ);
  assign s_we     = r_we;
  assign s_sel    = r_sel;
  assign s_addr   = r_addr;
  assign s_data_o = r_data;
  assign m_stall  = (state != IDLE);
  assign m_ack    = v[STAGES-1] & ~e[STAGES-1];
  assign m_err    = v[STAGES-1] & e[STAGES-1];
  assign m_data_i = d[STAGES-1];
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state  <= IDLE;
      cnt    <= '0;
      r_we   <= 1'b0;
      r_sel  <= '0;
      r_addr <= '0;
      r_data <= '0;
      v      <= '0;
      e      <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        r_we   <= m_we;
        r_sel  <= m_sel;
        r_addr <= m_addr;
        r_data <= m_data_o;
        cnt    <= '0;
      end else if (state == REQ && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      v[0] <= cap;
      if (cap) begin
        e[0] <= ~s_ack;
        d[0] <= s_ack ? s_data_i : '0;
      end
      // data and err only advance with a valid token so the last stage holds between responses
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) begin
          e[i] <= e[i-1];
          d[i] <= d[i-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_resp_pipe.sv
// tb_wb_resp_pipe: directed checks on three bridges (STAGES 1/3/4, TIMEOUT 8) driven in lockstep.
module tb_wb_resp_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, m_cyc, m_stb, m_we, s_ack;
  logic [3:0] m_sel;
  logic [31:0] m_addr, m_data_o, s_data_i;
  logic [2:0] ack, err, stall, scyc, sstb, swe;
  logic [31:0] rdata [3];
  logic [31:0] saddr [3];
  logic [31:0] sdo [3];
  logic [3:0] ssel [3];
  localparam int ST [3] = '{1, 3, 4};
  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_resp_pipe #(.DATA_W(32), .ADDR_W(32), .STAGES(g == 0 ? 1 : g + 2), .TIMEOUT(8)) u_dut (
      .clk_core(clk), .rst_core(rst),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_data_o(m_data_o),
      .m_data_i(rdata[g]), .m_ack(ack[g]), .m_err(err[g]), .m_stall(stall[g]),
      .s_cyc(scyc[g]), .s_stb(sstb[g]), .s_we(swe[g]), .s_sel(ssel[g]), .s_addr(saddr[g]),
      .s_data_o(sdo[g]), .s_data_i(s_data_i), .s_ack(s_ack)
    );
  end
  int tests = 0, fails = 0, cyc = 0, both_n = 0, n0, na;
  int ack_n [3], err_n [3], ack_at [3], err_at [3];
  logic [31:0] ack_dat [3], err_dat [3];
  logic stall_ack [3];
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (ack[k]) begin ack_n[k]++; ack_at[k] = cyc; ack_dat[k] = rdata[k]; stall_ack[k] = stall[k]; end
      if (err[k]) begin err_n[k]++; err_at[k] = cyc; err_dat[k] = rdata[k]; end
      if (ack[k] && err[k]) both_n++;
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic clr();
    for (int k = 0; k < 3; k++) begin
      ack_n[k] = 0; err_n[k] = 0; ack_at[k] = -1; err_at[k] = -1; stall_ack[k] = 1'b0;
    end
    both_n = 0;
  endtask
  task automatic start_req(input logic we, input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] data);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_addr = addr; m_data_o = data;
    tick();
    m_stb = 1'b0;
    n0 = cyc;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    ticks(2);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({ack[k], err[k], stall[k], scyc[k], sstb[k], swe[k]} !== 6'b0) begin
        fails++; $display("FAIL reset_ctrl[%0d] got %b want 000000", k, {ack[k], err[k], stall[k], scyc[k], sstb[k], swe[k]});
      end
      tests++;
      if (rdata[k] !== 32'h0 || saddr[k] !== 32'h0 || sdo[k] !== 32'h0 || ssel[k] !== 4'h0) begin
        fails++; $display("FAIL reset_data[%0d] got %h/%h/%h/%h want zeros", k, rdata[k], saddr[k], sdo[k], ssel[k]);
      end
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_read();
    clr();
    start_req(1'b0, 4'hf, 32'h100, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (!scyc[k] || !sstb[k] || swe[k] !== 1'b0 || saddr[k] !== 32'h100) begin
        fails++; $display("FAIL read_req[%0d] got cyc=%b stb=%b we=%b addr=%h want 1 1 0 100", k, scyc[k], sstb[k], swe[k], saddr[k]);
      end
    end
    ticks(2);
    s_ack = 1'b1; s_data_i = 32'hDEADBEEF;
    tick();
    na = cyc;
    s_ack = 1'b0; s_data_i = 32'h0;
    tests++;
    if (scyc !== 3'b000 || stall !== 3'b111) begin
      fails++; $display("FAIL read_after_ack got s_cyc=%b stall=%b want 000 111", scyc, stall);
    end
    ticks(6);
    m_cyc = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (ack_n[k] != 1 || err_n[k] != 0 || ack_at[k] != na + ST[k] - 1) begin
        fails++; $display("FAIL read_pulse[%0d] got acks=%0d errs=%0d at=%0d want 1 0 %0d", k, ack_n[k], err_n[k], ack_at[k], na + ST[k] - 1);
      end
      tests++;
      if (ack_dat[k] !== 32'hDEADBEEF || rdata[k] !== 32'hDEADBEEF || stall_ack[k] !== 1'b1) begin
        fails++; $display("FAIL read_data[%0d] got %h hold=%h stall=%b want deadbeef 1", k, ack_dat[k], rdata[k], stall_ack[k]);
      end
    end
  endtask
  task automatic test_write();
    clr();
    start_req(1'b1, 4'b0011, 32'h200, 32'h12345678);
    m_we = 1'b0; m_sel = 4'hc; m_data_o = 32'hFFFF0000; m_addr = 32'h999;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (!sstb[k] || swe[k] !== 1'b1 || ssel[k] !== 4'b0011 || sdo[k] !== 32'h12345678 || saddr[k] !== 32'h200) begin
        fails++; $display("FAIL write_req[%0d] got stb=%b we=%b sel=%b data=%h addr=%h want 1 1 0011 12345678 200", k, sstb[k], swe[k], ssel[k], sdo[k], saddr[k]);
      end
    end
    s_ack = 1'b1; s_data_i = 32'h0BADF00D;
    tick();
    na = cyc;
    tick();
    s_ack = 1'b0;
    ticks(6);
    m_cyc = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (ack_n[k] != 1 || err_n[k] != 0 || ack_at[k] != na + ST[k] - 1) begin
        fails++; $display("FAIL write_pulse[%0d] got acks=%0d errs=%0d at=%0d want 1 0 %0d", k, ack_n[k], err_n[k], ack_at[k], na + ST[k] - 1);
      end
    end
    tests++;
    if (both_n != 0) begin fails++; $display("FAIL write_ack_err_overlap got %0d want 0", both_n); end
  endtask
  task automatic test_timeout();
    clr();
    start_req(1'b0, 4'hf, 32'h300, 32'h0);
    ticks(9);
    na = cyc;
    tests++;
    if (scyc !== 3'b000 || stall !== 3'b111) begin
      fails++; $display("FAIL timeout_exit got s_cyc=%b stall=%b want 000 111", scyc, stall);
    end
    ticks(6);
    m_cyc = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (err_n[k] != 1 || ack_n[k] != 0 || err_at[k] != na + ST[k] - 1) begin
        fails++; $display("FAIL timeout_pulse[%0d] got errs=%0d acks=%0d at=%0d want 1 0 %0d", k, err_n[k], ack_n[k], err_at[k], na + ST[k] - 1);
      end
      tests++;
      if (err_dat[k] !== 32'h0 || rdata[k] !== 32'h0 || scyc[k] !== 1'b0) begin
        fails++; $display("FAIL timeout_data[%0d] got %h hold=%h s_cyc=%b want 0 0 0", k, err_dat[k], rdata[k], scyc[k]);
      end
    end
  endtask
  task automatic test_expiry_ack();
    clr();
    start_req(1'b0, 4'hf, 32'h400, 32'h0);
    ticks(8);
    s_ack = 1'b1; s_data_i = 32'hCAFE0033;
    tick();
    na = cyc;
    s_ack = 1'b0;
    ticks(6);
    m_cyc = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (ack_n[k] != 1 || err_n[k] != 0 || ack_at[k] != na + ST[k] - 1 || ack_dat[k] !== 32'hCAFE0033) begin
        fails++; $display("FAIL expiry_ack[%0d] got acks=%0d errs=%0d at=%0d data=%h want 1 0 %0d cafe0033", k, ack_n[k], err_n[k], ack_at[k], ack_dat[k], na + ST[k] - 1);
      end
    end
  endtask
  task automatic test_abort();
    clr();
    start_req(1'b0, 4'hf, 32'h500, 32'h0);
    ticks(2);
    m_cyc = 1'b0;
    tick();
    tests++;
    if (scyc !== 3'b000 || sstb !== 3'b000 || stall !== 3'b000) begin
      fails++; $display("FAIL abort_drop got s_cyc=%b s_stb=%b stall=%b want 000 000 000", scyc, sstb, stall);
    end
    ticks(12);
    s_ack = 1'b1; s_data_i = 32'h11111111;
    tick();
    s_ack = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (ack_n[k] != 0 || err_n[k] != 0) begin
        fails++; $display("FAIL abort_silent[%0d] got acks=%0d errs=%0d want 0 0", k, ack_n[k], err_n[k]);
      end
    end
    start_req(1'b0, 4'hf, 32'h600, 32'h0);
    s_ack = 1'b1; s_data_i = 32'h600D600D;
    tick();
    na = cyc;
    s_ack = 1'b0;
    ticks(6);
    m_cyc = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (ack_n[k] != 1 || ack_at[k] != na + ST[k] - 1 || ack_dat[k] !== 32'h600D600D) begin
        fails++; $display("FAIL abort_next[%0d] got acks=%0d at=%0d data=%h want 1 %0d 600d600d", k, ack_n[k], ack_at[k], ack_dat[k], na + ST[k] - 1);
      end
    end
  endtask
  task automatic test_reset_resp();
    clr();
    start_req(1'b0, 4'hf, 32'h700, 32'h0);
    s_ack = 1'b1; s_data_i = 32'h77777777;
    tick();
    s_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({ack[k], err[k], stall[k], scyc[k]} !== 4'b0 || rdata[k] !== 32'h0) begin
        fails++; $display("FAIL rst_resp_out[%0d] got ctl=%b data=%h want 0000 0", k, {ack[k], err[k], stall[k], scyc[k]}, rdata[k]);
      end
    end
    ticks(6);
    m_cyc = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (ack_n[k] != (k == 0 ? 1 : 0) || err_n[k] != 0) begin
        fails++; $display("FAIL rst_resp_pulse[%0d] got acks=%0d errs=%0d want %0d 0", k, ack_n[k], err_n[k], k == 0 ? 1 : 0);
      end
    end
  endtask
  initial begin
    rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = 4'h0;
    m_addr = 32'h0; m_data_o = 32'h0; s_data_i = 32'h0; s_ack = 1'b0;
    clr();
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_expiry_ack();
    test_abort();
    test_reset_resp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
